// File: rtl/dram_timing_pkg.sv
// Shared timing defaults, counter sizing helpers and sequencer state encoding
// for the DRAM command path; the TimingFSM bench can import the same constants.
package dram_timing_pkg;

    localparam int DEF_T_RCD  = 17;
    localparam int DEF_T_CL   = 17;
    localparam int DEF_T_WR   = 14;
    localparam int DEF_T_RP   = 17;
    localparam int DEF_T_RFC  = 34;
    localparam int DEF_T_REFI = 10400;
    localparam int DEF_BL     = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters hold N-1 at most, so clog2(N) bits are enough.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    localparam int CNT_W = cnt_width(max2(max2(max2(DEF_T_RCD, DEF_T_RP), max2(DEF_T_WR, DEF_T_RFC)),
                                          DEF_T_CL + DEF_BL / 2));

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_PRE_WAIT,
        ST_ACT,
        ST_ACT_WAIT,
        ST_CAS,
        ST_CAS_WAIT,
        ST_PREA,
        ST_PREA_WAIT,
        ST_REFR,
        ST_REF_WAIT
    } seq_state_t;

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-page tracker: one open bit plus the open row for every bank,
// with a combinational lookup of the incoming request against its bank entry.
module open_row_table #(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int ROWWIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] lookup_bg,
    input  logic [BAWIDTH-1:0]                     lookup_ba,
    input  logic [ROWWIDTH-1:0]                    lookup_row,
    output logic                                   hit,
    output logic                                   conflict,
    output logic                                   any_open,
    input  logic                                   set_en,
    input  logic                                   clr_en,
    input  logic                                   clr_all,
    input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] upd_bg,
    input  logic [BAWIDTH-1:0]                     upd_ba,
    input  logic [ROWWIDTH-1:0]                    upd_row
);
    localparam int IDX_W = BGWIDTH + BAWIDTH;
    localparam int NB    = 1 << IDX_W;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [NB-1:0]    open_bits;
    logic [NB-1:0]    match_bits;

    // Without bank groups the group index collapses to a single entry.
    generate
        if (BGWIDTH > 0) begin : g_bg
            assign lookup_idx = {lookup_bg, lookup_ba};
            assign upd_idx    = {upd_bg, upd_ba};
        end else begin : g_nobg
            assign lookup_idx = lookup_ba;
            assign upd_idx    = upd_ba;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_entry
            logic                open_reg;
            logic [ROWWIDTH-1:0] row_reg;

            always_ff @(posedge clk) begin
                if (reset || clr_all) begin
                    open_reg <= 1'b0;
                end else if (set_en && (upd_idx == IDX_W'(gi))) begin
                    open_reg <= 1'b1;
                    row_reg  <= upd_row;
                end else if (clr_en && (upd_idx == IDX_W'(gi))) begin
                    open_reg <= 1'b0;
                end
            end

            assign open_bits[gi]  = open_reg;
            assign match_bits[gi] = open_reg && (row_reg == lookup_row);
        end
    endgenerate

    assign hit      = match_bits[lookup_idx];
    assign conflict = open_bits[lookup_idx] && !match_bits[lookup_idx];
    assign any_open = |open_bits;

endmodule

// File: rtl/dram_cmd_sequencer.sv
// DRAM command sequencer: turns single read/write requests into spaced PR/ACT/RD/WR
// strobes under an open-page policy and interleaves periodic all-bank refresh.
module dram_cmd_sequencer
    import dram_timing_pkg::*;
#(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int ROWWIDTH = 16,
    parameter int BL       = DEF_BL,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_CL     = DEF_T_CL,
    parameter int T_WR     = DEF_T_WR,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RFC    = DEF_T_RFC,
    parameter int T_REFI   = DEF_T_REFI
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_write,
    input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] req_bg,
    input  logic [BAWIDTH-1:0]                     req_ba,
    input  logic [ROWWIDTH-1:0]                    req_row,
    output logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] cmd_bg,
    output logic [BAWIDTH-1:0]                     cmd_ba,
    output logic [ROWWIDTH-1:0]                    cmd_row,
    output logic                                   ACT,
    output logic                                   PR,
    output logic                                   PRA,
    output logic                                   RD,
    output logic                                   WR,
    output logic                                   REF,
    output logic                                   rsp_valid
);
    localparam int BGW     = (BGWIDTH > 0) ? BGWIDTH : 1;
    localparam int RD_WAIT = T_CL + BL / 2;
    localparam int SEQ_W   = cnt_width(max2(max2(max2(T_RCD, T_RP), max2(T_WR, T_RFC)), RD_WAIT));
    localparam int RC_W    = cnt_width(T_REFI);

    seq_state_t           state_reg, state_next;
    logic [SEQ_W-1:0]     cnt_reg, cnt_next;
    logic [RC_W-1:0]      ref_cnt_reg;
    logic                 ref_pending_reg;
    logic                 rsp_valid_reg;
    logic                 write_reg;
    logic [BGW-1:0]       bg_reg;
    logic [BAWIDTH-1:0]   ba_reg;
    logic [ROWWIDTH-1:0]  row_reg;

    logic                 accept;
    logic                 cnt_zero;
    logic                 cas_done;
    logic                 in_refresh_strobe;
    logic                 hit, conflict, any_open;
    logic [SEQ_W-1:0]     cas_load_req, cas_load_held;

    assign req_ready     = (state_reg == ST_IDLE) && !ref_pending_reg;
    assign accept        = req_valid && req_ready;
    assign cnt_zero      = (cnt_reg == '0);
    assign cas_load_req  = req_write ? SEQ_W'(T_WR - 1) : SEQ_W'(RD_WAIT - 1);
    assign cas_load_held = write_reg ? SEQ_W'(T_WR - 1) : SEQ_W'(RD_WAIT - 1);
    assign cas_done      = ((state_reg == ST_CAS) || (state_reg == ST_CAS_WAIT)) && cnt_zero;

    open_row_table #(
        .BGWIDTH  (BGWIDTH),
        .BAWIDTH  (BAWIDTH),
        .ROWWIDTH (ROWWIDTH)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .lookup_bg  (req_bg),
        .lookup_ba  (req_ba),
        .lookup_row (req_row),
        .hit        (hit),
        .conflict   (conflict),
        .any_open   (any_open),
        .set_en     (state_reg == ST_ACT),
        .clr_en     (state_reg == ST_PRE),
        .clr_all    (state_reg == ST_PREA),
        .upd_bg     (bg_reg),
        .upd_ba     (ba_reg),
        .upd_row    (row_reg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The wait counter is loaded with N-1 on entry to a strobe state, so the
    // strobe cycle itself is the first counted cycle of the interval.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ref_pending_reg) begin
                    if (any_open) begin
                        state_next = ST_PREA;
                        cnt_next   = SEQ_W'(T_RP - 1);
                    end else begin
                        state_next = ST_REFR;
                        cnt_next   = SEQ_W'(T_RFC - 1);
                    end
                end else if (accept) begin
                    if (hit) begin
                        state_next = ST_CAS;
                        cnt_next   = cas_load_req;
                    end else if (conflict) begin
                        state_next = ST_PRE;
                        cnt_next   = SEQ_W'(T_RP - 1);
                    end else begin
                        state_next = ST_ACT;
                        cnt_next   = SEQ_W'(T_RCD - 1);
                    end
                end
            end
            ST_PRE, ST_PRE_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_ACT;
                    cnt_next   = SEQ_W'(T_RCD - 1);
                end else begin
                    state_next = ST_PRE_WAIT;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_ACT, ST_ACT_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_CAS;
                    cnt_next   = cas_load_held;
                end else begin
                    state_next = ST_ACT_WAIT;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_CAS, ST_CAS_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_CAS_WAIT;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_PREA, ST_PREA_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_REFR;
                    cnt_next   = SEQ_W'(T_RFC - 1);
                end else begin
                    state_next = ST_PREA_WAIT;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_REFR, ST_REF_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_REF_WAIT;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A new expiry outranks the clear so a refresh is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
        end else if (ref_cnt_reg == RC_W'(T_REFI - 1)) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b1;
        end else begin
            ref_cnt_reg <= ref_cnt_reg + 1'b1;
            if (state_reg == ST_REFR) begin
                ref_pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg     <= 1'b0;
            bg_reg        <= '0;
            ba_reg        <= '0;
            row_reg       <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= cas_done && !write_reg;
            if (accept) begin
                write_reg <= req_write;
                bg_reg    <= req_bg;
                ba_reg    <= req_ba;
                row_reg   <= req_row;
            end
        end
    end

    assign in_refresh_strobe = (state_reg == ST_PREA) || (state_reg == ST_REFR);

    assign cmd_bg    = in_refresh_strobe ? '0 : bg_reg;
    assign cmd_ba    = in_refresh_strobe ? '0 : ba_reg;
    assign cmd_row   = in_refresh_strobe ? '0 : row_reg;
    assign ACT       = (state_reg == ST_ACT);
    assign PR        = (state_reg == ST_PRE);
    assign PRA       = (state_reg == ST_PREA);
    assign REF       = (state_reg == ST_REFR);
    assign RD        = (state_reg == ST_CAS) && !write_reg;
    assign WR        = (state_reg == ST_CAS) && write_reg;
    assign rsp_valid = rsp_valid_reg;

endmodule
